// File: rtl/dcache_controller.sv
`default_nettype none
// ============================================================================
// Module   : dcache_controller
// Purpose  : Direct-mapped, write-back, write-allocate data cache controller
//            (16 lines x 32 bytes) sitting between the MEM stage and memory.
// Revision : 1.0 - initial release
// ============================================================================
module dcache_controller (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         cpu_req_i,
  input  logic         cpu_we_i,
  input  logic [31:0]  cpu_addr_i,
  input  logic [31:0]  cpu_data_i,
  output logic [31:0]  cpu_data_o,
  output logic         cpu_stall_o,
  output logic         mem_req_o,
  output logic         mem_we_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i
);

  localparam int c_NUM_LINES = 16;
  localparam int c_TAG_W     = 23;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_ALLOCATE  = 2'd2
  } state_t;

  state_t               r_state;
  logic [c_NUM_LINES-1:0] r_valid;
  logic [c_NUM_LINES-1:0] r_dirty;
  logic [c_TAG_W-1:0]   r_tag  [c_NUM_LINES];
  logic [255:0]         r_data [c_NUM_LINES];
  logic [3:0]           r_miss_idx;
  logic [c_TAG_W-1:0]   r_miss_tag;

  logic [c_TAG_W-1:0]   w_tag;
  logic [3:0]           w_idx;
  logic [2:0]           w_word;
  logic                 w_hit;
  logic                 w_idle;
  logic                 w_unused_addr;

  assign w_tag         = cpu_addr_i[31:9];
  assign w_idx         = cpu_addr_i[8:5];
  assign w_word        = cpu_addr_i[4:2];
  assign w_unused_addr = &{1'b0, cpu_addr_i[1:0]};
  assign w_idle        = (r_state == ST_IDLE);
  assign w_hit         = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

  // CPU side is purely combinational so a hit costs no stall cycle.
  assign cpu_stall_o = !w_idle || (cpu_req_i && !w_hit);
  assign cpu_data_o  = (w_idle && cpu_req_i && !cpu_we_i && w_hit)
                     ? r_data[w_idx][{w_word, 5'b0} +: 32] : 32'h0;

  always_comb begin
    mem_req_o  = 1'b0;
    mem_we_o   = 1'b0;
    mem_addr_o = 32'h0;
    mem_data_o = 256'h0;
    case (r_state)
      ST_WRITEBACK: begin
        mem_req_o  = 1'b1;
        mem_we_o   = 1'b1;
        mem_addr_o = {r_tag[r_miss_idx], r_miss_idx, 5'b0};
        mem_data_o = r_data[r_miss_idx];
      end
      ST_ALLOCATE: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {r_miss_tag, r_miss_idx, 5'b0};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_valid <= '0;
      r_dirty <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cpu_req_i) begin
            if (w_hit) begin
              if (cpu_we_i) begin
                r_data[w_idx][{w_word, 5'b0} +: 32] <= cpu_data_i;
                r_dirty[w_idx] <= 1'b1;
              end
            end else begin
              // Index and tag are frozen here and used for the whole miss.
              r_miss_idx <= w_idx;
              r_miss_tag <= w_tag;
              r_state    <= (r_valid[w_idx] && r_dirty[w_idx])
                          ? ST_WRITEBACK : ST_ALLOCATE;
            end
          end
        end
        ST_WRITEBACK: begin
          if (mem_ack_i) r_state <= ST_ALLOCATE;
        end
        ST_ALLOCATE: begin
          if (mem_ack_i) begin
            r_data[r_miss_idx]  <= mem_data_i;
            r_tag[r_miss_idx]   <= r_miss_tag;
            r_valid[r_miss_idx] <= 1'b1;
            r_dirty[r_miss_idx] <= 1'b0;
            r_state             <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dcache_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache_controller
// Purpose  : Scoreboard bench for dcache_controller with a latency-programmable
//            memory model and a word-level reference of architectural memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dcache_controller;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         cpu_req_i = 1'b0;
  logic         cpu_we_i = 1'b0;
  logic [31:0]  cpu_addr_i = 32'h0;
  logic [31:0]  cpu_data_i = 32'h0;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic         mem_req_o;
  logic         mem_we_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i = 256'h0;
  logic         mem_ack_i = 1'b0;

  dcache_controller u_dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cpu_req_i   (cpu_req_i),
    .cpu_we_i    (cpu_we_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_data_i  (cpu_data_i),
    .cpu_data_o  (cpu_data_o),
    .cpu_stall_o (cpu_stall_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_data_o  (mem_data_o),
    .mem_data_i  (mem_data_i),
    .mem_ack_i   (mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mem_words [logic [29:0]];
  logic [31:0] ref_words [logic [29:0]];
  logic [31:0] exp_q [$];

  int           n_stall;
  logic         wb_seen, al_seen;
  logic [31:0]  wb_addr, al_addr;
  logic [255:0] wb_blk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [29:0] wa);
    return {wa, 2'b00} ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_words.exists(a[31:2]) ? ref_words[a[31:2]] : init_word(a[31:2]);
  endfunction

  function automatic logic [255:0] mem_read(input logic [31:0] blk);
    logic [255:0] r;
    logic [29:0]  wa;
    for (int w = 0; w < 8; w++) begin
      wa = {blk[31:5], 3'(w)};
      r[w*32 +: 32] = mem_words.exists(wa) ? mem_words[wa] : init_word(wa);
    end
    return r;
  endfunction

  task automatic mem_write(input logic [31:0] blk, input logic [255:0] d);
    for (int w = 0; w < 8; w++) mem_words[{blk[31:5], 3'(w)}] = d[w*32 +: 32];
  endtask

  // Drive one CPU access until the stall drops; memory answers after lat cycles.
  task automatic access(input logic we, input logic [31:0] a, input logic [31:0] d, input int lat);
    int   cnt;
    logic done;
    logic [31:0] exp;
    cpu_req_i = 1'b1; cpu_we_i = we; cpu_addr_i = a; cpu_data_i = d;
    if (!we) exp_q.push_back(ref_read(a));
    else     ref_words[a[31:2]] = d;
    n_stall = 0; wb_seen = 0; al_seen = 0; wb_addr = 0; al_addr = 0; wb_blk = 0;
    cnt = 0; done = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk_i);
      if (!cpu_stall_o) begin
        if (!we) begin
          exp = exp_q.pop_front();
          check("rdata", cpu_data_o, exp);
        end
        done = 1;
        break;
      end
      n_stall++;
      if (mem_req_o) begin
        cnt++;
        if (mem_we_o) begin wb_seen = 1; wb_addr = mem_addr_o; wb_blk = mem_data_o; end
        else begin al_seen = 1; al_addr = mem_addr_o; end
        if (cnt == lat) begin
          mem_ack_i = 1'b1;
          if (mem_we_o) mem_write(mem_addr_o, mem_data_o);
          else          mem_data_i = mem_read(mem_addr_o);
          cnt = 0;
        end
      end
      @(posedge clk_i); #1;
      mem_ack_i = 1'b0;
    end
    if (!done) check("timeout", 32'd0, 32'd1);
    @(posedge clk_i); #1;
    cpu_req_i = 1'b0;
  endtask

  initial begin
    mem_words[30'h41] = 32'hDEADBEEF;
    ref_words[30'h41] = 32'hDEADBEEF;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    check("rst_stall", {31'b0, cpu_stall_o}, 32'd0);
    check("rst_mreq",  {31'b0, mem_req_o}, 32'd0);
    check("rst_maddr", mem_addr_o, 32'd0);
    check("rst_mdata", {31'b0, |mem_data_o}, 32'd0);
    check("rst_rdata", cpu_data_o, 32'd0);
    @(posedge clk_i); #1;

    access(1'b0, 32'h0000_0104, 32'h0, 3);
    check("cold_stall", n_stall, 32'd4);
    check("cold_nowb",  {31'b0, wb_seen}, 32'd0);
    check("cold_aladdr", al_addr, 32'h0000_0100);

    access(1'b1, 32'h0000_0108, 32'h1234_5678, 1);
    check("sthit_stall", n_stall, 32'd0);
    access(1'b0, 32'h0000_010B, 32'h0, 1);
    check("ldhit_stall", n_stall, 32'd0);

    access(1'b0, 32'h0000_0300, 32'h0, 2);
    check("dirty_wb", {31'b0, wb_seen}, 32'd1);
    check("dirty_wbaddr", wb_addr, 32'h0000_0100);
    check("dirty_wbw2", wb_blk[95:64], 32'h1234_5678);
    check("dirty_aladdr", al_addr, 32'h0000_0300);
    check("dirty_stall", n_stall, 32'd5);

    access(1'b0, 32'h0000_0500, 32'h0, 1);
    check("clean_nowb", {31'b0, wb_seen}, 32'd0);
    check("clean_aladdr", al_addr, 32'h0000_0500);
    check("clean_stall", n_stall, 32'd2);

    access(1'b1, 32'h0000_0040, 32'hA5A5_A5A5, 1);
    check("stmiss_nowb", {31'b0, wb_seen}, 32'd0);
    check("stmiss_al", {31'b0, al_seen}, 32'd1);
    check("stmiss_aladdr", al_addr, 32'h0000_0040);
    check("stmiss_stall", n_stall, 32'd2);
    access(1'b0, 32'h0000_0040, 32'h0, 1);
    check("stmiss_ld_stall", n_stall, 32'd0);
    access(1'b0, 32'h0000_0240, 32'h0, 1);
    check("stmiss_dirty_wb", {31'b0, wb_seen}, 32'd1);
    check("stmiss_wbaddr", wb_addr, 32'h0000_0040);
    check("stmiss_wbw0", wb_blk[31:0], 32'hA5A5_A5A5);
    check("evict_stall", n_stall, 32'd3);

    access(1'b0, 32'h0000_0108, 32'h0, 1);
    check("refetch_nowb", {31'b0, wb_seen}, 32'd0);
    check("refetch_stall", n_stall, 32'd2);

    // Reset during the second ALLOCATE cycle, late ack one cycle after.
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0000_0600;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    rst_i = 1'b1; cpu_req_i = 1'b0;
    @(negedge clk_i);
    check("midrst_inalloc", {31'b0, mem_req_o}, 32'd1);
    @(posedge clk_i); #1;
    rst_i = 1'b0; mem_ack_i = 1'b1; mem_data_i = {256{1'b1}};
    @(negedge clk_i);
    check("midrst_mreq", {31'b0, mem_req_o}, 32'd0);
    check("midrst_stall", {31'b0, cpu_stall_o}, 32'd0);
    @(posedge clk_i); #1;
    mem_ack_i = 1'b0;

    access(1'b0, 32'h0000_0600, 32'h0, 1);
    check("postrst_stall", n_stall, 32'd2);
    check("postrst_aladdr", al_addr, 32'h0000_0600);
    access(1'b0, 32'h0000_0108, 32'h0, 1);
    check("postrst_cold_nowb", {31'b0, wb_seen}, 32'd0);
    check("postrst_cold_stall", n_stall, 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dcache_controller.md
DCACHE_CONTROLLER -- requirements
Module: dcache_controller

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset, ports listed first: clk_i input 1 (rising-edge clock); rst_i input 1 (synchronous, active-high reset).
REQ-002 SHALL have these CPU-side (MEM stage) ports:
- cpu_req_i input 1: MemRead or MemWrite active this cycle.
- cpu_we_i input 1: 1 = store, 0 = load.
- cpu_addr_i input 32: byte address.
- cpu_data_i input 32: store data.
- cpu_data_o output 32: load data, fed to the MEM/WB register.
- cpu_stall_o output 1: drives Data_Stall of all pipeline registers.
REQ-003 SHALL have these memory-side ports:
- mem_req_o output 1: memory request.
- mem_we_o output 1: 1 = write-back, 0 = refill.
- mem_addr_o output 32: block-aligned address.
- mem_data_o output 256: write-back block.
- mem_data_i input 256: refill block.
- mem_ack_i input 1: one-cycle completion pulse.

Function
REQ-004 SHALL be a direct-mapped, write-back, write-allocate cache with 16 lines of 32 bytes each.
REQ-005 SHALL split cpu_addr_i as follows: tag = [31:9] (23 bits), index = [8:5], word = [4:2]; bits [1:0] SHALL be ignored.
REQ-006 SHALL hold, per line, a valid bit, a dirty bit, a 23-bit tag, and 256 bits of data.
REQ-007 SHALL define a hit as valid[index] AND tag[index] == addr tag, evaluated combinationally in IDLE.
REQ-008 SHALL use three states: IDLE, WRITEBACK, ALLOCATE.
REQ-009 SHALL handle IDLE with no request: cpu_stall_o = 0 and no state change.
REQ-010 SHALL handle an IDLE load hit: cpu_data_o = selected word in the same cycle, cpu_stall_o = 0.
REQ-011 SHALL handle an IDLE store hit: cpu_stall_o = 0; at the clock edge the selected word is updated and dirty is set.
REQ-012 SHALL handle an IDLE miss: cpu_stall_o = 1 in the same cycle. Next state is WRITEBACK if the victim is valid and dirty, otherwise ALLOCATE.
REQ-013 SHALL, in WRITEBACK, drive mem_req_o = 1, mem_we_o = 1, mem_addr_o = {victim tag, index, 5'b0}, mem_data_o = victim data, and hold them until mem_ack_i; on ack the next state is ALLOCATE.
REQ-014 SHALL, in ALLOCATE, drive mem_req_o = 1, mem_we_o = 0, mem_addr_o = {addr[31:5], 5'b0}, and hold them until mem_ack_i. On ack it SHALL write mem_data_i into the line, set valid, clear dirty, load the new tag, and return to IDLE.
REQ-015 SHALL hold cpu_stall_o = 1 throughout WRITEBACK and ALLOCATE.
REQ-016 SHALL, on return to IDLE, re-evaluate the still-held CPU access as a hit, so a store miss completes as a store hit, with dirty set, one cycle after the refill.
REQ-017 SHALL have a miss penalty of (write-back cycles) + (refill cycles) + 1 cycle of stall.
REQ-018 SHALL treat mem_ack_i as don't-care in IDLE.
REQ-019 SHALL count an ack arriving in the first cycle of a state as completion, giving a minimum of 1 cycle per state.
REQ-020 SHALL drive mem_req_o = 0, mem_we_o = 0, and all-zero mem_addr_o/mem_data_o in IDLE.
REQ-021 SHALL drive cpu_data_o = 0 when there is no load hit.
REQ-022 SHALL rely on the CPU holding cpu_req_i, cpu_we_i, cpu_addr_i, and cpu_data_i stable while cpu_stall_o = 1. Changes during a stall are unsupported; the captured index and tag SHALL be used for the whole miss.

Reset
REQ-023 SHALL, when rst_i = 1 at a rising edge, enter IDLE and clear all valid and dirty bits. Tag and data contents are don't-care.
REQ-024 SHALL, on reset asserted mid-miss (WRITEBACK or ALLOCATE), abandon the transaction. Next cycle outputs: mem_req_o = 0, cpu_stall_o = 0 if cpu_req_i = 0, and no line is updated by a late ack.
REQ-025 SHALL, after reset, treat every access as a miss to a clean line: the first access goes directly to ALLOCATE.

Verification
REQ-026 Cold load miss: reset; load 0x0000_0104; memory acks after 3 cycles with word1 = 0xDEADBEEF -> stall for 4 cycles (3 in ALLOCATE plus 1 re-evaluation); no WRITEBACK entered; cpu_data_o = 0xDEADBEEF on the hit cycle.
REQ-027 Store hit: after REQ-026, store 0x1234_5678 to 0x0000_0108 -> stall 0; the next load of 0x108 returns 0x12345678, and the line is dirty.
REQ-028 Dirty eviction: after REQ-027, load 0x0000_0300 (index 8, same as 0x100; tag differs) -> WRITEBACK with mem_addr_o = 0x0000_0100, mem_we_o = 1, and mem_data_o word2 = 0x12345678; then ALLOCATE with mem_addr_o = 0x0000_0300.
REQ-029 Clean eviction: load 0x0000_0500 (same index) after the REQ-028 refill -> no WRITEBACK; direct ALLOCATE.
REQ-030 Store miss allocate: store 0xA5A5A5A5 to an uncached 0x0000_0040 -> ALLOCATE, then a 1-cycle hit that writes word0; the line is dirty, and a following load returns 0xA5A5A5A5.
REQ-031 Reset mid-miss: assert rst_i during the second ALLOCATE cycle and ack one cycle later -> IDLE, mem_req_o = 0, and a re-load of the same address misses again.
